// File: rtl/k005297_pkg.sv
// k005297 shared types and constants
// used by the page deserializer blocks
package k005297_pkg;

  localparam int BYTE_W = 8;
  localparam int K005297_PAGE_BYTES_DEF = 130;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } pg_state_t;

endpackage

// File: rtl/k005297_sipo8.sv
// k005297 8-bit LSB-first serial-in shifter
// byte strobe fires on the 8th enabled bit
module k005297_sipo8
  import k005297_pkg::*;
(
  input  logic              i_MCLK,
  input  logic              i_SYS_RST_n,
  input  logic              clr,
  input  logic              en,
  input  logic              bdi,
  output logic [BYTE_W-1:0] data,
  output logic              stb
);

  logic [BYTE_W-1:0] sreg;
  logic [2:0]        bitcnt;

  assign data = {bdi, sreg[BYTE_W-1:1]};
  assign stb  = en && !clr && (bitcnt == 3'd7);

  // shift new bits in at the top so the first bit lands in bit 0
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      sreg   <= '0;
      bitcnt <= '0;
    end else if (clr) begin
      sreg   <= '0;
      bitcnt <= '0;
    end else if (en) begin
      sreg   <= data;
      bitcnt <= bitcnt + 3'd1;
    end
  end

endmodule

// File: rtl/k005297_pgdeser.sv
// k005297 page deserializer
// bytes out via valid/ack, page done and overrun flags
module k005297_pgdeser
  import k005297_pkg::*;
#(
  parameter int PAGE_BYTES = K005297_PAGE_BYTES_DEF
) (
  input  logic              i_MCLK,
  input  logic              i_SYS_RST_n,
  input  logic              i_CLK2M_PCEN_n,
  input  logic              i_BDI,
  input  logic              i_GLCNT_RD,
  input  logic              i_SYNCTIP_n,
  input  logic              i_SYNCED_FLAG,
  input  logic              i_ABORT,
  input  logic              i_BYTE_ACK,
  output logic [BYTE_W-1:0] o_BYTE,
  output logic              o_BYTE_VALID,
  output logic              o_PAGE_DONE,
  output logic              o_OVERRUN,
  output logic              o_BUSY,
  output logic [7:0]        o_BYTECNT
);

  localparam logic [7:0] PB = 8'(PAGE_BYTES);

  pg_state_t         state;
  logic              pcen;
  logic              start;
  logic              shift_en;
  logic              clr;
  logic              stb;
  logic              last;
  logic [BYTE_W-1:0] data;

  assign pcen     = !i_CLK2M_PCEN_n;
  assign start    = pcen && (state == ST_IDLE) && !i_SYNCTIP_n
                    && i_SYNCED_FLAG && !i_ABORT;
  assign shift_en = pcen && (state == ST_SHIFT) && i_GLCNT_RD
                    && !i_ABORT;
  assign clr      = start || i_ABORT;
  assign last     = stb && ((o_BYTECNT + 8'd1) == PB);

  assign o_BUSY      = (state == ST_SHIFT);
  assign o_PAGE_DONE = (state == ST_DONE);

  k005297_sipo8 u_sipo (
    .i_MCLK      (i_MCLK),
    .i_SYS_RST_n (i_SYS_RST_n),
    .clr         (clr),
    .en          (shift_en),
    .bdi         (i_BDI),
    .data        (data),
    .stb         (stb)
  );

  // page FSM; abort drops straight back to idle
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      state <= ST_IDLE;
    end else if (i_ABORT) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (start) state <= ST_SHIFT;
        ST_SHIFT: if (last)  state <= ST_DONE;
        ST_DONE:  if (pcen)  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // byte handoff, overrun and byte count; a load beats an ack
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      o_BYTE       <= '0;
      o_BYTE_VALID <= 1'b0;
      o_OVERRUN    <= 1'b0;
      o_BYTECNT    <= '0;
    end else begin
      if (start) begin
        o_BYTECNT <= '0;
        o_OVERRUN <= 1'b0;
      end
      if (stb) begin
        o_BYTECNT <= o_BYTECNT + 8'd1;
        if (!o_BYTE_VALID || i_BYTE_ACK) begin
          o_BYTE       <= data;
          o_BYTE_VALID <= 1'b1;
        end else begin
          o_OVERRUN <= 1'b1;
        end
      end else if (i_BYTE_ACK) begin
        o_BYTE_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_k005297_pgdeser.sv
// k005297_pgdeser directed testbench
// short page (4 bytes) so page completion is reachable
module tb_k005297_pgdeser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pcen_n;
  logic       bdi;
  logic       gl;
  logic       tip_n;
  logic       synced;
  logic       abt;
  logic       ack;
  logic [7:0] obyte;
  logic       ovalid;
  logic       odone;
  logic       oovr;
  logic       obusy;
  logic [7:0] ocnt;

  int n_cmp = 0;
  int n_fail = 0;
  int done_pulses = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  k005297_pgdeser #(.PAGE_BYTES(4)) dut (
    .i_MCLK         (clk),
    .i_SYS_RST_n    (rst_n),
    .i_CLK2M_PCEN_n (pcen_n),
    .i_BDI          (bdi),
    .i_GLCNT_RD     (gl),
    .i_SYNCTIP_n    (tip_n),
    .i_SYNCED_FLAG  (synced),
    .i_ABORT        (abt),
    .i_BYTE_ACK     (ack),
    .o_BYTE         (obyte),
    .o_BYTE_VALID   (ovalid),
    .o_PAGE_DONE    (odone),
    .o_OVERRUN      (oovr),
    .o_BUSY         (obusy),
    .o_BYTECNT      (ocnt)
  );

  task automatic cyc(input bit en, input bit b, input bit g,
                     input bit tp, input bit sy, input bit ak,
                     input bit ab);
    @(negedge clk);
    pcen_n = !en;
    bdi    = b;
    gl     = g;
    tip_n  = tp;
    synced = sy;
    ack    = ak;
    abt    = ab;
    @(posedge clk);
    #1;
    if (odone && !prev_done) done_pulses++;
    prev_done = odone;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 1, 1, 0, 0);
  endtask

  task automatic ack_cyc();
    cyc(0, 0, 0, 1, 1, 1, 0);
  endtask

  task automatic abort_cyc();
    cyc(0, 0, 0, 1, 1, 0, 1);
  endtask

  task automatic tip_cyc(input bit sy);
    cyc(1, 1, 1, 0, sy, 0, 0);
  endtask

  task automatic bit_cyc(input bit b, input bit ak);
    idle_cyc();
    cyc(1, b, 1, 1, 1, ak, 0);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit ak_last);
    for (int i = 0; i < 8; i++) bit_cyc(v[i], ak_last && (i == 7));
  endtask

  task automatic send_byte_gl(input logic [7:0] v, input bit ak_last);
    for (int i = 0; i < 8; i++) begin
      cyc(1, !v[i], 0, 1, 1, 0, 0);
      idle_cyc();
      cyc(1, v[i], 1, 1, 1, ak_last && (i == 7), 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pcen_n = 1'b1; bdi = 0; gl = 0; tip_n = 1;
    synced = 1; abt = 0; ack = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({obyte, ovalid, odone, oovr, obusy, ocnt} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_in: got %h want 0",
               {obyte, ovalid, odone, oovr, obusy, ocnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cyc();
    idle_cyc();
    n_cmp++;
    if ({obyte, ovalid, odone, oovr, obusy, ocnt} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_out: got %h want 0",
               {obyte, ovalid, odone, oovr, obusy, ocnt});
    end
  endtask

  task automatic test_basic();
    tip_cyc(1);
    n_cmp++;
    if (obusy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b want 1", obusy);
    end
    send_byte(8'hA5, 0);
    n_cmp++;
    if ({ovalid, obyte, ocnt} !== {1'b1, 8'hA5, 8'd1}) begin
      n_fail++;
      $display("FAIL basic_b0: got v=%b b=%h c=%0d want v=1 b=a5 c=1",
               ovalid, obyte, ocnt);
    end
    ack_cyc();
    n_cmp++;
    if (ovalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ack: got %b want 0", ovalid);
    end
    send_byte(8'h0F, 0);
    n_cmp++;
    if ({ovalid, obyte, ocnt, oovr} !== {1'b1, 8'h0F, 8'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_b1: got v=%b b=%h c=%0d o=%b want 1 0f 2 0",
               ovalid, obyte, ocnt, oovr);
    end
    ack_cyc();
    abort_cyc();
    n_cmp++;
    if (obusy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_abort_busy: got %b want 0", obusy);
    end
  endtask

  task automatic test_page_done();
    logic [7:0] pat [4];
    int p0;
    pat[0] = 8'h3C; pat[1] = 8'h81; pat[2] = 8'h5A; pat[3] = 8'hC3;
    p0 = done_pulses;
    tip_cyc(1);
    for (int k = 0; k < 4; k++) begin
      send_byte_gl(pat[k], 1);
      n_cmp++;
      if ({ovalid, obyte, ocnt} !== {1'b1, pat[k], 8'(k + 1)}) begin
        n_fail++;
        $display("FAIL page_b%0d: got v=%b b=%h c=%0d want 1 %h %0d",
                 k, ovalid, obyte, ocnt, pat[k], k + 1);
      end
      n_cmp++;
      if (odone !== (k == 3)) begin
        n_fail++;
        $display("FAIL page_done%0d: got %b want %b", k, odone, k == 3);
      end
    end
    n_cmp++;
    if (obusy !== 1'b0) begin
      n_fail++;
      $display("FAIL page_busy: got %b want 0", obusy);
    end
    idle_cyc();
    n_cmp++;
    if (odone !== 1'b1) begin
      n_fail++;
      $display("FAIL page_done_hold: got %b want 1", odone);
    end
    cyc(1, 0, 0, 1, 1, 0, 0);
    idle_cyc();
    n_cmp++;
    if ({odone, obusy, ocnt} !== {1'b0, 1'b0, 8'd4}) begin
      n_fail++;
      $display("FAIL page_end: got d=%b b=%b c=%0d want 0 0 4",
               odone, obusy, ocnt);
    end
    n_cmp++;
    if (done_pulses - p0 !== 1) begin
      n_fail++;
      $display("FAIL page_pulses: got %0d want 1", done_pulses - p0);
    end
    ack_cyc();
  endtask

  task automatic test_no_sync();
    tip_cyc(0);
    n_cmp++;
    if (obusy !== 1'b0) begin
      n_fail++;
      $display("FAIL nosync_busy: got %b want 0", obusy);
    end
    send_byte(8'h77, 0);
    n_cmp++;
    if ({ovalid, ocnt, obusy} !== {1'b0, 8'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL nosync_idle: got v=%b c=%0d b=%b want 0 4 0",
               ovalid, ocnt, obusy);
    end
  endtask

  task automatic test_overrun();
    tip_cyc(1);
    send_byte(8'h11, 0);
    n_cmp++;
    if ({ovalid, obyte, oovr} !== {1'b1, 8'h11, 1'b0}) begin
      n_fail++;
      $display("FAIL ovr_b0: got v=%b b=%h o=%b want 1 11 0",
               ovalid, obyte, oovr);
    end
    send_byte(8'h22, 0);
    n_cmp++;
    if ({ovalid, obyte, oovr, ocnt} !== {1'b1, 8'h11, 1'b1, 8'd2}) begin
      n_fail++;
      $display("FAIL ovr_drop: got v=%b b=%h o=%b c=%0d want 1 11 1 2",
               ovalid, obyte, oovr, ocnt);
    end
    send_byte(8'h33, 1);
    n_cmp++;
    if ({ovalid, obyte, ocnt, obusy} !== {1'b1, 8'h33, 8'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL ovr_ackload: got v=%b b=%h c=%0d bz=%b want 1 33 3 1",
               ovalid, obyte, ocnt, obusy);
    end
  endtask

  task automatic test_abort();
    int p0;
    p0 = done_pulses;
    bit_cyc(1, 0);
    bit_cyc(1, 0);
    bit_cyc(1, 0);
    abort_cyc();
    n_cmp++;
    if ({obusy, oovr, ovalid, obyte} !== {1'b0, 1'b1, 1'b1, 8'h33}) begin
      n_fail++;
      $display("FAIL abort_hold: got bz=%b o=%b v=%b b=%h want 0 1 1 33",
               obusy, oovr, ovalid, obyte);
    end
    ack_cyc();
    tip_cyc(1);
    n_cmp++;
    if ({oovr, ocnt, obusy} !== {1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_restart: got o=%b c=%0d bz=%b want 0 0 1",
               oovr, ocnt, obusy);
    end
    send_byte(8'h96, 0);
    n_cmp++;
    if ({ovalid, obyte, ocnt} !== {1'b1, 8'h96, 8'd1}) begin
      n_fail++;
      $display("FAIL abort_fresh: got v=%b b=%h c=%0d want 1 96 1",
               ovalid, obyte, ocnt);
    end
    n_cmp++;
    if (done_pulses - p0 !== 0) begin
      n_fail++;
      $display("FAIL abort_nodone: got %0d want 0", done_pulses - p0);
    end
  endtask

  task automatic test_async_reset();
    bit_cyc(1, 0);
    bit_cyc(0, 0);
    bit_cyc(1, 0);
    bit_cyc(1, 0);
    @(negedge clk);
    pcen_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({obyte, ovalid, odone, oovr, obusy, ocnt} !== 20'h0) begin
      n_fail++;
      $display("FAIL async_rst: got %h want 0",
               {obyte, ovalid, odone, oovr, obusy, ocnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hFF, 0);
    n_cmp++;
    if ({ovalid, obusy, ocnt} !== {1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL async_after: got v=%b bz=%b c=%0d want 0 0 0",
               ovalid, obusy, ocnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_page_done();
    test_no_sync();
    test_overrun();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
